// File: rtl/tx_pkt_reader_if.sv
// TX FIFO read side and MAC transmit side of the packet reader, grouped as one bundle.
// master = reader (drives FIFO read and MAC beats), slave = FIFO/MAC environment.
interface tx_pkt_reader_if;
    logic [63:0] tx_fifo_data;
    logic        tx_fifo_empty;
    logic [12:0] tx_fifo_usedw;
    logic        tx_fifo_rd;
    logic [63:0] mac_tx_data;
    logic        mac_tx_valid;
    logic        mac_tx_sop;
    logic        mac_tx_eop;
    logic [2:0]  mac_tx_mod;
    logic        mac_tx_ready;
    logic        hdr_err;
    logic [31:0] pkt_cnt;

    modport master (
        input  tx_fifo_data, tx_fifo_empty, tx_fifo_usedw, mac_tx_ready,
        output tx_fifo_rd, mac_tx_data, mac_tx_valid, mac_tx_sop, mac_tx_eop,
        output mac_tx_mod, hdr_err, pkt_cnt
    );

    modport slave (
        output tx_fifo_data, tx_fifo_empty, tx_fifo_usedw, mac_tx_ready,
        input  tx_fifo_rd, mac_tx_data, mac_tx_valid, mac_tx_sop, mac_tx_eop,
        input  mac_tx_mod, hdr_err, pkt_cnt
    );
endinterface

// File: rtl/tx_pkt_reader.sv
// Store-and-forward frame reader: header qword + data qwords from TX FIFO to MAC; first beat 5 cycles after header read.
// MAC backpressure absorbed by a head register plus two skid slots; FIFO reads throttled so in-flight data always fits.
module tx_pkt_reader #(
    parameter logic [15:0] MAX_BYTES = 16'd9600
) (
    input  logic          clk,
    input  logic          reset,
    tx_pkt_reader_if.master bus
);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        HDR  = 5'b00010,
        WAIT = 5'b00100,
        DATA = 5'b01000,
        DONE = 5'b10000
    } state_t;

    state_t      state_q, state_d;
    logic        rd_q, rd_d;
    logic        dvld_q;
    logic [2:0]  mod_q, mod_d;
    logic [12:0] qw_q, qw_d;
    logic [12:0] rd_rem_q, rd_rem_d;
    logic [12:0] send_rem_q, send_rem_d;
    logic [63:0] buf_q [3];
    logic [63:0] buf_d [3];
    logic [1:0]  cnt_q, cnt_d, cnt_mid;
    logic        hdr_err_q, hdr_err_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic        pop, push;
    logic [15:0] hdr_bc;

    always_comb begin
        state_d    = state_q;
        rd_d       = 1'b0;
        mod_d      = mod_q;
        qw_d       = qw_q;
        rd_rem_d   = rd_rem_q;
        send_rem_d = send_rem_q;
        hdr_err_d  = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        buf_d      = buf_q;
        hdr_bc     = bus.tx_fifo_data[15:0];

        // buf_q[0] is the beat on the MAC; entries behind it hold beats already read while the MAC stalls
        pop     = (cnt_q != 2'd0) && bus.mac_tx_ready;
        push    = dvld_q && (state_q == DATA);
        cnt_mid = cnt_q - {1'b0, pop};
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end
        if (push) begin
            case (cnt_mid)
                2'd0:    buf_d[0] = bus.tx_fifo_data;
                2'd1:    buf_d[1] = bus.tx_fifo_data;
                default: buf_d[2] = bus.tx_fifo_data;
            endcase
        end
        cnt_d = cnt_mid + {1'b0, push};

        case (state_q)
            IDLE: begin
                if (!bus.tx_fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (dvld_q) begin
                    qw_d  = 13'((17'(hdr_bc) + 17'd7) >> 3);
                    mod_d = hdr_bc[2:0];
                    if (hdr_bc == 16'd0 || hdr_bc > MAX_BYTES) begin
                        hdr_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        rd_rem_d   = qw_d;
                        send_rem_d = qw_d;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.tx_fifo_usedw >= qw_q) begin
                    rd_d     = 1'b1;
                    rd_rem_d = rd_rem_q - 13'd1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                // Skid slots in use after this cycle plus the read still in flight must leave room for one more
                if (rd_rem_q != 13'd0 && ({1'b0, cnt_d} + {2'b00, rd_q}) < 3'd3) begin
                    rd_d     = 1'b1;
                    rd_rem_d = rd_rem_q - 13'd1;
                end
                if (pop) begin
                    send_rem_d = send_rem_q - 13'd1;
                    if (send_rem_q == 13'd1) begin
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        state_d   = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            dvld_q     <= 1'b0;
            mod_q      <= 3'd0;
            qw_q       <= 13'd0;
            rd_rem_q   <= 13'd0;
            send_rem_q <= 13'd0;
            buf_q      <= '{default: '0};
            cnt_q      <= 2'd0;
            hdr_err_q  <= 1'b0;
            pkt_cnt_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            dvld_q     <= rd_q;
            mod_q      <= mod_d;
            qw_q       <= qw_d;
            rd_rem_q   <= rd_rem_d;
            send_rem_q <= send_rem_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            hdr_err_q  <= hdr_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign bus.tx_fifo_rd   = rd_q;
    assign bus.mac_tx_valid = (cnt_q != 2'd0);
    assign bus.mac_tx_data  = bus.mac_tx_valid ? buf_q[0] : 64'd0;
    assign bus.mac_tx_sop   = bus.mac_tx_valid && (send_rem_q == qw_q);
    assign bus.mac_tx_eop   = bus.mac_tx_valid && (send_rem_q == 13'd1);
    assign bus.mac_tx_mod   = bus.mac_tx_eop ? mod_q : 3'd0;
    assign bus.hdr_err      = hdr_err_q;
    assign bus.pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_tx_pkt_reader.sv
// Bench for tx_pkt_reader: FIFO model, directed frames, scoreboard of expected MAC beats checked by a monitor.
module tb_tx_pkt_reader;

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
    } beat_t;

    logic clk;
    logic reset;
    logic flush;
    logic rdy_mode;
    tx_pkt_reader_if bus();

    tx_pkt_reader #(.MAX_BYTES(16'd9600)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [63:0] mem [512];
    int pushes = 0;
    int pops   = 0;
    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int hdr_cnt = 0;
    beat_t exp_q[$];

    assign bus.tx_fifo_empty = (pushes == pops);
    assign bus.tx_fifo_usedw = 13'(pushes - pops);

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: data appears the cycle after a read strobe
    initial begin
        bus.tx_fifo_data = 64'd0;
        forever begin
            @(posedge clk);
            cyc++;
            if (flush) begin
                pops <= pushes;
            end else if (bus.tx_fifo_rd) begin
                check("rd_while_empty", 72'(pushes == pops), 72'(0));
                bus.tx_fifo_data <= mem[pops % 512];
                pops <= pops + 1;
            end
        end
    end

    initial begin
        bus.mac_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) bus.mac_tx_ready = ~bus.mac_tx_ready;
            else bus.mac_tx_ready = 1'b1;
        end
    end

    // Monitor: scoreboard pops, hold-while-stalled, hdr_err pulse count
    initial begin
        beat_t cur, prev, e;
        logic prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = '{d: bus.mac_tx_data, sop: bus.mac_tx_sop, eop: bus.mac_tx_eop, mod: bus.mac_tx_mod};
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", 72'({bus.mac_tx_valid, cur}), 72'({1'b1, prev}));
                if (bus.mac_tx_valid && bus.mac_tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h with no beat expected (cycle %0d)", cur, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 72'(cur), 72'(e));
                    end
                end
                if (bus.hdr_err) hdr_cnt++;
                prev_stall = bus.mac_tx_valid && !bus.mac_tx_ready;
                prev = cur;
            end
        end
    end

    function automatic logic [63:0] dat(input int tag, input int i);
        return {8'(tag), 24'hC0DE5A, 32'h1000_0000 + 32'(i)};
    endfunction

    task automatic push_q(input logic [63:0] d);
        mem[pushes % 512] = d;
        pushes++;
    endtask

    // Header plus the first nq data qwords; expected beats for the whole frame
    task automatic send_frame(input logic [15:0] bc, input int nq, input int tag);
        int qw;
        beat_t b;
        qw = (int'(bc) + 7) >> 3;
        push_q({48'hFACE_0000_BEEF, bc});
        for (int i = 0; i < qw; i++) begin
            b.d   = dat(tag, i);
            b.sop = (i == 0);
            b.eop = (i == qw - 1);
            b.mod = (i == qw - 1) ? bc[2:0] : 3'd0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < nq; i++) push_q(dat(tag, i));
    endtask

    task automatic wait_pkt(input int target, input int budget);
        for (int i = 0; i < budget && bus.pkt_cnt != 32'(target); i++) @(negedge clk);
        check("pkt_cnt", 72'(bus.pkt_cnt), 72'(target));
    endtask

    initial begin
        int t_hdr, lat, n, cnt_rd, cnt_vld, h0;
        reset = 1'b1;
        flush = 1'b1;
        rdy_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd", 72'(bus.tx_fifo_rd), 72'(0));
        check("rst_valid", 72'(bus.mac_tx_valid), 72'(0));
        check("rst_mac", 72'({bus.mac_tx_data, bus.mac_tx_sop, bus.mac_tx_eop, bus.mac_tx_mod}), 72'(0));
        check("rst_hdr_err", 72'(bus.hdr_err), 72'(0));
        check("rst_pkt_cnt", 72'(bus.pkt_cnt), 72'(0));
        reset = 1'b0;
        flush = 1'b0;
        @(negedge clk);

        // bc=64: latency, back-to-back beats, mod 0
        send_frame(16'd64, 8, 1);
        t_hdr = -100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.tx_fifo_rd) begin t_hdr = cyc; break; end
        end
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.mac_tx_valid) begin lat = cyc - t_hdr; break; end
            @(negedge clk);
        end
        check("first_valid_latency", 72'(lat), 72'(5));
        n = bus.mac_tx_valid ? 1 : 0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (bus.mac_tx_valid) n++;
        end
        check("no_bubble_beats", 72'(n), 72'(8));
        wait_pkt(1, 40);

        // bc=61: eop mod 5
        send_frame(16'd61, 8, 2);
        wait_pkt(2, 60);

        // bc=100 with 5 of 13 qwords: held in WAIT
        send_frame(16'd100, 5, 3);
        for (int i = 0; i < 10 && !bus.tx_fifo_rd; i++) @(negedge clk);
        cnt_rd = 0;
        cnt_vld = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_fifo_rd) cnt_rd++;
            if (bus.mac_tx_valid) cnt_vld++;
        end
        check("wait_no_rd", 72'(cnt_rd), 72'(0));
        check("wait_no_valid", 72'(cnt_vld), 72'(0));
        for (int i = 5; i < 13; i++) push_q(dat(3, i));
        wait_pkt(3, 80);

        // bc=128 with ready toggling every cycle
        rdy_mode = 1'b1;
        send_frame(16'd128, 16, 4);
        wait_pkt(4, 200);
        rdy_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Illegal headers: bc=0 and bc=9601
        h0 = hdr_cnt;
        push_q({48'h0123_4567_89AB, 16'd0});
        push_q({48'h0123_4567_89AB, 16'd9601});
        cnt_vld = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.mac_tx_valid) cnt_vld++;
        end
        check("hdr_err_pulses", 72'(hdr_cnt - h0), 72'(2));
        check("hdr_err_no_valid", 72'(cnt_vld), 72'(0));
        check("hdr_err_pkt_cnt", 72'(bus.pkt_cnt), 72'(4));
        check("hdr_err_fifo_drained", 72'(pushes - pops), 72'(0));

        // Reset at beat 3 of a 16-beat frame
        send_frame(16'd128, 16, 5);
        for (int i = 0; i < 20 && !bus.mac_tx_valid; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_rd", 72'(bus.tx_fifo_rd), 72'(0));
        check("midrst_mac", 72'({bus.mac_tx_valid, bus.mac_tx_data, bus.mac_tx_sop, bus.mac_tx_eop, bus.mac_tx_mod}), 72'(0));
        check("midrst_cnt_err", 72'({bus.pkt_cnt, bus.hdr_err}), 72'(0));
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_idle_no_rd", 72'(bus.tx_fifo_rd), 72'(0));

        // bc=1: single beat, sop=eop=1, mod=1
        send_frame(16'd1, 1, 6);
        wait_pkt(1, 40);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 72'(exp_q.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
